axi_lite_detector_regs: RTL and testbench

AXI4-Lite slave register file for the coincidence detector; this is the responder the AXI master VIP talks to. Holds four 32-bit read/write configuration registers and a saturating coincidence event counter. Drives the enable and window settings into the detector core. Sits between the PS/VIP master port and the detector datapath inside the block design.

---
 rtl/axi_detector_pkg.sv | 38 +++
 rtl/axi_detector_event_cnt.sv | 31 +++
 rtl/axi_lite_detector_regs.sv | 164 ++++++++++++++++
 tb/tb_axi_lite_detector_regs.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_detector_pkg.sv
// Shared constants and types for the coincidence detector AXI4-Lite register file.
// Register offsets are word indices, i.e. addr[4:2].
package axi_detector_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_WINDOW = 3'd1;
  localparam logic [2:0] REG_SCR2   = 3'd2;
  localparam logic [2:0] REG_SCR3   = 3'd3;
  localparam logic [2:0] REG_COUNT  = 3'd4;

  localparam int CTRL_CLR_BIT = 1;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[i*8 +: 8] = strb[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_detector_event_cnt.sv
// Saturating 32-bit coincidence event counter; clear has priority over increment.
module axi_detector_event_cnt (
  input  logic        clock,
  input  logic        reset,
  input  logic        clr,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/axi_lite_detector_regs.sv
// AXI4-Lite register file for the coincidence detector: CTRL, WINDOW, two
// scratch registers and a read-only saturating event COUNT.
//   state  | meaning
//   W_IDLE | waiting for AW and W together
//   W_RESP | holding bvalid/bresp until bready
//   R_IDLE | arready high, waiting for AR
//   R_DATA | holding rvalid/rdata/rresp until rready
module axi_lite_detector_regs
  import axi_detector_pkg::*;
#(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_ADDR_WIDTH = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [C_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [2:0]              s_axi_awprot,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [C_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [3:0]              s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [C_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [2:0]              s_axi_arprot,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [C_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  input  logic                    coinc_pulse,
  output logic [31:0]             ctrl_out,
  output logic [31:0]             window_out
);

  w_state_t    w_state_q, w_state_d;
  r_state_t    r_state_q, r_state_d;
  resp_t       bresp_q, bresp_d;
  resp_t       rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] ctrl_q, ctrl_d;
  logic [31:0] window_q, window_d;
  logic [31:0] scr2_q, scr2_d;
  logic [31:0] scr3_q, scr3_d;
  logic [31:0] count;
  logic        cnt_clr;
  logic        wr_hs;
  logic [2:0]  w_idx, r_idx;
  logic        unused_in;

  assign unused_in = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign wr_hs = (w_state_q == W_IDLE) && s_axi_awvalid && s_axi_wvalid;
  assign w_idx = s_axi_awaddr[4:2];
  assign r_idx = s_axi_araddr[4:2];

  always_comb begin
    w_state_d = w_state_q;
    bresp_d   = bresp_q;
    ctrl_d    = ctrl_q;
    window_d  = window_q;
    scr2_d    = scr2_q;
    scr3_d    = scr3_q;
    cnt_clr   = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (wr_hs) begin
          w_state_d = W_RESP;
          bresp_d   = OKAY;
          case (w_idx)
            REG_CTRL: begin
              ctrl_d = apply_wstrb(ctrl_q, s_axi_wdata, s_axi_wstrb);
              // clear bit is a strobe, never stored
              ctrl_d[CTRL_CLR_BIT] = 1'b0;
              cnt_clr = s_axi_wstrb[CTRL_CLR_BIT/8] & s_axi_wdata[CTRL_CLR_BIT];
            end
            REG_WINDOW: window_d = apply_wstrb(window_q, s_axi_wdata, s_axi_wstrb);
            REG_SCR2:   scr2_d   = apply_wstrb(scr2_q, s_axi_wdata, s_axi_wstrb);
            REG_SCR3:   scr3_d   = apply_wstrb(scr3_q, s_axi_wdata, s_axi_wstrb);
            REG_COUNT:  bresp_d  = OKAY;
            default:    bresp_d  = SLVERR;
          endcase
        end
      end
      W_RESP:  if (s_axi_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (s_axi_arvalid) begin
          r_state_d = R_DATA;
          rresp_d   = OKAY;
          case (r_idx)
            REG_CTRL:   rdata_d = ctrl_q;
            REG_WINDOW: rdata_d = window_q;
            REG_SCR2:   rdata_d = scr2_q;
            REG_SCR3:   rdata_d = scr3_q;
            REG_COUNT:  rdata_d = count;
            default: begin
              rdata_d = '0;
              rresp_d = SLVERR;
            end
          endcase
        end
      end
      R_DATA:  if (s_axi_rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      bresp_q   <= OKAY;
      rresp_q   <= OKAY;
      rdata_q   <= '0;
      ctrl_q    <= '0;
      window_q  <= '0;
      scr2_q    <= '0;
      scr3_q    <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      ctrl_q    <= ctrl_d;
      window_q  <= window_d;
      scr2_q    <= scr2_d;
      scr3_q    <= scr3_d;
    end
  end

  axi_detector_event_cnt u_event_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (coinc_pulse),
    .count (count)
  );

  assign s_axi_awready = wr_hs;
  assign s_axi_wready  = wr_hs;
  assign s_axi_bvalid  = (w_state_q == W_RESP);
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = (r_state_q == R_IDLE);
  assign s_axi_rvalid  = (r_state_q == R_DATA);
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign ctrl_out      = ctrl_q;
  assign window_out    = window_q;

endmodule

// File: tb/tb_axi_lite_detector_regs.sv
// Bench for axi_lite_detector_regs: directed vector table, hand-written corner
// sequences, then randomized traffic checked against a register-map model.
module tb_axi_lite_detector_regs;

  localparam logic [1:0] R_OKAY   = 2'b00;
  localparam logic [1:0] R_SLVERR = 2'b10;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  s_axi_awaddr;
  logic [2:0]  s_axi_awprot;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [4:0]  s_axi_araddr;
  logic [2:0]  s_axi_arprot;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic        coinc_pulse;
  logic [31:0] ctrl_out;
  logic [31:0] window_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  axi_lite_detector_regs dut (
    .clock         (clock),
    .reset         (reset),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awprot  (s_axi_awprot),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arprot  (s_axi_arprot),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .coinc_pulse   (coinc_pulse),
    .ctrl_out      (ctrl_out),
    .window_out    (window_out)
  );

  typedef struct {
    bit          wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[$];

  // reference model state
  logic [31:0] m_regs [4];
  longint      m_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic get_bresp(output logic [1:0] resp);
    logic got;
    int   cyc;
    got = 1'b0;
    cyc = 0;
    resp = 2'bxx;
    s_axi_bready = 1'b1;
    while (!got && cyc < 16) begin
      @(negedge clock);
      got  = s_axi_bvalid;
      resp = s_axi_bresp;
      @(posedge clock); #1;
      cyc++;
    end
    s_axi_bready = 1'b0;
    check("bvalid_seen", 32'(got), 32'd1);
  endtask

  task automatic get_rdata(output logic [31:0] data, output logic [1:0] resp);
    logic got;
    int   cyc;
    got = 1'b0;
    cyc = 0;
    data = 'x;
    resp = 2'bxx;
    s_axi_rready = 1'b1;
    while (!got && cyc < 16) begin
      @(negedge clock);
      got  = s_axi_rvalid;
      data = s_axi_rdata;
      resp = s_axi_rresp;
      @(posedge clock); #1;
      cyc++;
    end
    s_axi_rready = 1'b0;
    check("rvalid_seen", 32'(got), 32'd1);
  endtask

  // pulse=1 raises coinc_pulse for the handshake cycle only
  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input bit pulse, output logic [1:0] resp);
    logic hs;
    int   cyc;
    hs = 1'b0;
    cyc = 0;
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    coinc_pulse = pulse;
    while (!hs && cyc < 16) begin
      @(negedge clock);
      hs = s_axi_awready & s_axi_wready;
      @(posedge clock); #1;
      cyc++;
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; coinc_pulse = 1'b0;
    check("aw_w_handshake", 32'(hs), 32'd1);
    get_bresp(resp);
  endtask

  task automatic axi_read(input logic [4:0] addr, input bit pulse,
                          output logic [31:0] data, output logic [1:0] resp);
    logic hs;
    int   cyc;
    hs = 1'b0;
    cyc = 0;
    s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    coinc_pulse = pulse;
    while (!hs && cyc < 16) begin
      @(negedge clock);
      hs = s_axi_arready;
      @(posedge clock); #1;
      cyc++;
    end
    s_axi_arvalid = 1'b0; coinc_pulse = 1'b0;
    check("ar_handshake", 32'(hs), 32'd1);
    get_rdata(data, resp);
  endtask

  task automatic pulses(input int n);
    if (n > 0) begin
      coinc_pulse = 1'b1;
      repeat (n) begin @(posedge clock); #1; end
      coinc_pulse = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) begin @(posedge clock); #1; end
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rsp;
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    logic [2:0]  idx;

    s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    coinc_pulse = 1'b0;
    do_reset();

    // reset state
    check("rst_awready", 32'(s_axi_awready), 32'd0);
    check("rst_wready",  32'(s_axi_wready),  32'd0);
    check("rst_arready", 32'(s_axi_arready), 32'd1);
    check("rst_bvalid",  32'(s_axi_bvalid),  32'd0);
    check("rst_rvalid",  32'(s_axi_rvalid),  32'd0);
    check("rst_bresp",   32'(s_axi_bresp),   32'd0);
    check("rst_rresp",   32'(s_axi_rresp),   32'd0);
    check("rst_rdata",   s_axi_rdata,        32'd0);
    check("rst_ctrl",    ctrl_out,           32'd0);
    check("rst_window",  window_out,         32'd0);

    // directed vector table
    vecs.push_back('{1'b1, 5'h08, 32'hAABBCCDD, 4'b0101, 32'h0,        R_OKAY});
    vecs.push_back('{1'b0, 5'h08, 32'h0,        4'h0,    32'h00BB00DD, R_OKAY});
    vecs.push_back('{1'b1, 5'h00, 32'h1,        4'hF,    32'h0,        R_OKAY});
    vecs.push_back('{1'b1, 5'h04, 32'h2,        4'hF,    32'h0,        R_OKAY});
    vecs.push_back('{1'b1, 5'h08, 32'h3,        4'hF,    32'h0,        R_OKAY});
    vecs.push_back('{1'b1, 5'h0C, 32'h4,        4'hF,    32'h0,        R_OKAY});
    vecs.push_back('{1'b0, 5'h00, 32'h0,        4'h0,    32'h1,        R_OKAY});
    vecs.push_back('{1'b0, 5'h04, 32'h0,        4'h0,    32'h2,        R_OKAY});
    vecs.push_back('{1'b0, 5'h08, 32'h0,        4'h0,    32'h3,        R_OKAY});
    vecs.push_back('{1'b0, 5'h0C, 32'h0,        4'h0,    32'h4,        R_OKAY});
    vecs.push_back('{1'b1, 5'h08, 32'hFFFFFFFF, 4'h0,    32'h0,        R_OKAY});
    vecs.push_back('{1'b0, 5'h0B, 32'h0,        4'h0,    32'h3,        R_OKAY});
    vecs.push_back('{1'b0, 5'h14, 32'h0,        4'h0,    32'h0,        R_SLVERR});
    vecs.push_back('{1'b1, 5'h18, 32'hFFFFFFFF, 4'hF,    32'h0,        R_SLVERR});
    vecs.push_back('{1'b0, 5'h1C, 32'h0,        4'h0,    32'h0,        R_SLVERR});
    vecs.push_back('{1'b1, 5'h10, 32'hDEADBEEF, 4'hF,    32'h0,        R_OKAY});
    vecs.push_back('{1'b0, 5'h10, 32'h0,        4'h0,    32'h0,        R_OKAY});
    vecs.push_back('{1'b0, 5'h00, 32'h0,        4'h0,    32'h1,        R_OKAY});
    vecs.push_back('{1'b0, 5'h05, 32'h0,        4'h0,    32'h2,        R_OKAY});
    vecs.push_back('{1'b0, 5'h0C, 32'h0,        4'h0,    32'h4,        R_OKAY});

    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 1'b0, rsp);
        check($sformatf("vec%0d_bresp", i), 32'(rsp), 32'(vecs[i].exp_resp));
      end else begin
        axi_read(vecs[i].addr, 1'b0, rd, rsp);
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_data);
        check($sformatf("vec%0d_rresp", i), 32'(rsp), 32'(vecs[i].exp_resp));
      end
    end
    check("tbl_ctrl_out",   ctrl_out,   32'h1);
    check("tbl_window_out", window_out, 32'h2);

    // counting, clear racing a pulse, pre-increment read
    pulses(5);
    axi_read(5'h10, 1'b0, rd, rsp);
    check("count_5", rd, 32'd5);
    axi_write(5'h00, 32'h2, 4'hF, 1'b1, rsp);
    check("clr_bresp", 32'(rsp), 32'(R_OKAY));
    check("clr_ctrl_out", ctrl_out, 32'h0);
    axi_read(5'h10, 1'b0, rd, rsp);
    check("clr_count", rd, 32'd0);
    axi_read(5'h00, 1'b0, rd, rsp);
    check("clr_ctrl_rd", rd, 32'd0);
    pulses(2);
    axi_read(5'h10, 1'b1, rd, rsp);
    check("count_pre_inc", rd, 32'd2);
    axi_read(5'h10, 1'b0, rd, rsp);
    check("count_post_inc", rd, 32'd3);

    // saturation
    force dut.u_event_cnt.count_q = 32'hFFFF_FFFD;
    @(posedge clock); #1;
    release dut.u_event_cnt.count_q;
    pulses(1);
    axi_read(5'h10, 1'b0, rd, rsp);
    check("count_fffe", rd, 32'hFFFF_FFFE);
    pulses(3);
    axi_read(5'h10, 1'b0, rd, rsp);
    check("count_sat", rd, 32'hFFFF_FFFF);

    // AW leads W by 3 cycles, then held-off response
    s_axi_awaddr = 5'h14; s_axi_wdata = 32'h12345678; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("aw_only_awready", 32'(s_axi_awready), 32'd0);
      check("aw_only_wready",  32'(s_axi_wready),  32'd0);
      @(posedge clock); #1;
    end
    s_axi_wvalid = 1'b1;
    @(negedge clock);
    check("aw_w_awready", 32'(s_axi_awready), 32'd1);
    check("aw_w_wready",  32'(s_axi_wready),  32'd1);
    @(posedge clock); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    repeat (4) begin
      @(negedge clock);
      check("bp_bvalid", 32'(s_axi_bvalid), 32'd1);
      check("bp_bresp",  32'(s_axi_bresp),  32'(R_SLVERR));
      @(posedge clock); #1;
    end
    get_bresp(rsp);
    check("bp_bresp_final", 32'(rsp), 32'(R_SLVERR));

    s_axi_araddr = 5'h04; s_axi_arvalid = 1'b1;
    @(negedge clock);
    check("bp_arready", 32'(s_axi_arready), 32'd1);
    @(posedge clock); #1;
    s_axi_arvalid = 1'b0;
    repeat (4) begin
      @(negedge clock);
      check("bp_rvalid",  32'(s_axi_rvalid),  32'd1);
      check("bp_rdata",   s_axi_rdata,        32'h2);
      check("bp_rresp",   32'(s_axi_rresp),   32'(R_OKAY));
      check("bp_arready_busy", 32'(s_axi_arready), 32'd0);
      @(posedge clock); #1;
    end
    get_rdata(rd, rsp);
    check("bp_rdata_final", rd, 32'h2);
    @(negedge clock);
    check("bp_rvalid_drop", 32'(s_axi_rvalid), 32'd0);
    @(posedge clock); #1;

    // reset while the write response is pending
    s_axi_awaddr = 5'h08; s_axi_wdata = 32'h77; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    @(posedge clock); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    check("mid_bvalid", 32'(s_axi_bvalid), 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("mid_rst_bvalid",  32'(s_axi_bvalid),  32'd0);
    check("mid_rst_arready", 32'(s_axi_arready), 32'd1);
    check("mid_rst_window",  window_out,         32'd0);
    for (int a = 0; a < 5; a++) begin
      axi_read(5'(a * 4), 1'b0, rd, rsp);
      check($sformatf("mid_rst_reg%0d", a), rd, 32'd0);
    end

    // randomized traffic against the model
    for (int k = 0; k < 4; k++) m_regs[k] = '0;
    m_count = 0;
    for (int n = 0; n < 200; n++) begin
      logic [4:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      int          np;
      addr = 5'($urandom_range(0, 31));
      data = $urandom;
      strb = 4'($urandom_range(0, 15));
      idx  = addr[4:2];
      np   = $urandom_range(0, 3);
      pulses(np);
      m_count = m_count + np;
      if (m_count > 64'hFFFF_FFFF) m_count = 64'hFFFF_FFFF;
      if ($urandom_range(0, 1) == 1) begin
        axi_write(addr, data, strb, 1'b0, rsp);
        exp_r = (idx <= 3'd4) ? R_OKAY : R_SLVERR;
        if (idx < 3'd4) begin
          for (int b = 0; b < 4; b++)
            if (strb[b]) m_regs[idx][b*8 +: 8] = data[b*8 +: 8];
          if (idx == 3'd0) begin
            if (strb[0] && data[1]) m_count = 0;
            m_regs[0][1] = 1'b0;
          end
        end
        check($sformatf("rnd%0d_bresp", n), 32'(rsp), 32'(exp_r));
        check($sformatf("rnd%0d_ctrl_out", n), ctrl_out, m_regs[0]);
        check($sformatf("rnd%0d_window_out", n), window_out, m_regs[1]);
      end else begin
        axi_read(addr, 1'b0, rd, rsp);
        if (idx < 3'd4) begin
          exp_d = m_regs[idx]; exp_r = R_OKAY;
        end else if (idx == 3'd4) begin
          exp_d = 32'(m_count); exp_r = R_OKAY;
        end else begin
          exp_d = '0; exp_r = R_SLVERR;
        end
        check($sformatf("rnd%0d_rdata@%02h", n, addr), rd, exp_d);
        check($sformatf("rnd%0d_rresp", n), 32'(rsp), 32'(exp_r));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
